// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction fetch FIFO and IF/ID output register
module fetch_buffer #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_valid_i,
  input  logic [31:0]                fetch_inst_i,
  input  logic [31:0]                fetch_addr_i,
  output logic                       fetch_ready_o,
  input  logic                       hold_i,
  input  logic                       flush_i,
  output logic [31:0]                inst_o,
  output logic [31:0]                inst_addr_o,
  output logic                       inst_valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_addr [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          hs;
  logic          empty;
  logic          push;
  logic          pop;

  // Ready depends on occupancy only; a same-cycle pop does not open a slot
  always_comb begin
    fetch_ready_o = (count < CW'(DEPTH));
    hs            = fetch_valid_i && fetch_ready_o;
    empty         = (count == '0);
    pop           = !flush_i && !hold_i && !empty;
    // With an empty FIFO and no hold the handshake bypasses into the output
    push          = hs && !flush_i && (hold_i || !empty);
    count_o       = count;
  end

  // Entry storage needs no reset; count guards every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= fetch_inst_i;
      mem_addr[wr_ptr] <= fetch_addr_i;
    end
  end

  // Pointer, occupancy and output register update in priority order
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      inst_o       <= NOP_INST;
      inst_addr_o  <= '0;
      inst_valid_o <= 1'b0;
    end else if (flush_i) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      inst_o       <= NOP_INST;
      inst_addr_o  <= '0;
      inst_valid_o <= 1'b0;
    end else if (hold_i) begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        count  <= count + CW'(1);
      end
    end else if (pop) begin
      inst_o       <= mem_inst[rd_ptr];
      inst_addr_o  <= mem_addr[rd_ptr];
      inst_valid_o <= 1'b1;
      rd_ptr       <= rd_ptr + PW'(1);
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end else begin
        count  <= count - CW'(1);
      end
    end else if (hs) begin
      inst_o       <= fetch_inst_i;
      inst_addr_o  <= fetch_addr_i;
      inst_valid_o <= 1'b1;
    end else begin
      inst_o       <= NOP_INST;
      inst_addr_o  <= '0;
      inst_valid_o <= 1'b0;
    end
  end

endmodule
